// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_fetch_pkg;

  localparam int unsigned IFU_XLEN = 32;
  localparam logic [IFU_XLEN-1:0] IFU_RESET_PC = 32'hBFC0_0000;
  localparam int unsigned IFU_PC_STEP = 4;

  typedef enum logic [2:0] {
    IFU_ST_START = 3'd0,
    IFU_ST_REQ   = 3'd1,
    IFU_ST_WAIT  = 3'd2,
    IFU_ST_HOLD  = 3'd3,
    IFU_ST_ERR   = 3'd4
  } ifu_state_e;

  // Next-PC select codes used upstream to form redirect_pc.
  typedef enum logic [1:0] {
    IFU_SEL_NORM       = 2'd0,
    IFU_SEL_RELATIVE   = 2'd1,
    IFU_SEL_IRRELATIVE = 2'd2,
    IFU_SEL_REGISTER   = 2'd3
  } ifu_sel_e;

  typedef struct packed {
    logic [IFU_XLEN-1:0] pc;
    logic [IFU_XLEN-1:0] instr;
  } ifu_pkt_t;

  function automatic logic ifu_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_buf.sv
// One-entry valid/ready holding register; squash drops the entry and wins over load/transfer.
module ifu_buf
  import ifu_fetch_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  ifu_pkt_t load_pkt,
  input  logic     squash,
  input  logic     out_ready,
  output logic     valid,
  output ifu_pkt_t pkt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pkt   <= '0;
    end else if (squash) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pkt   <= load_pkt;
    end else if (valid && out_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, issues one imem read at a time, buffers the result for decode.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [IFU_XLEN-1:0] RESET_PC = IFU_RESET_PC,
  parameter int unsigned         PC_STEP  = IFU_PC_STEP
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [IFU_XLEN-1:0] imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [IFU_XLEN-1:0] imem_rsp_data,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [IFU_XLEN-1:0] if_pc,
  output logic [IFU_XLEN-1:0] if_instr,
  input  logic                redirect_valid,
  input  logic [IFU_XLEN-1:0] redirect_pc,
  output logic                fetch_misaligned
);

  ifu_state_e          state, state_n;
  logic [IFU_XLEN-1:0] pc, pc_n;
  logic                drop, drop_n;
  logic                buf_load;
  logic                outstanding;
  logic                buf_valid;
  ifu_pkt_t            buf_pkt;
  ifu_pkt_t            rsp_pkt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IFU_ST_START;
      pc               <= RESET_PC;
      drop             <= 1'b0;
      imem_req_valid   <= 1'b0;
      fetch_misaligned <= 1'b0;
    end else begin
      state            <= state_n;
      pc               <= pc_n;
      drop             <= drop_n;
      imem_req_valid   <= (state_n == IFU_ST_REQ);
      fetch_misaligned <= (state_n == IFU_ST_ERR);
    end
  end

  // Redirect first; 'outstanding' means a response is still owed after this edge and must be dropped.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    drop_n      = drop;
    buf_load    = 1'b0;
    outstanding = 1'b0;
    if (redirect_valid) begin
      case (state)
        IFU_ST_REQ:  outstanding = imem_req_ready;
        IFU_ST_WAIT: outstanding = !imem_rsp_valid;
        IFU_ST_ERR:  outstanding = drop && !imem_rsp_valid;
        default:     outstanding = 1'b0;
      endcase
      pc_n   = redirect_pc;
      drop_n = outstanding;
      if (ifu_misaligned(redirect_pc[1:0])) state_n = IFU_ST_ERR;
      else if (outstanding)                 state_n = IFU_ST_WAIT;
      else                                  state_n = IFU_ST_REQ;
    end else begin
      case (state)
        IFU_ST_START: state_n = IFU_ST_REQ;
        IFU_ST_REQ:   if (imem_req_ready) state_n = IFU_ST_WAIT;
        IFU_ST_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop) begin
              drop_n  = 1'b0;
              state_n = IFU_ST_REQ;
            end else begin
              buf_load = 1'b1;
              pc_n     = pc + IFU_XLEN'(PC_STEP);
              state_n  = IFU_ST_HOLD;
            end
          end
        end
        IFU_ST_HOLD:  if (if_ready) state_n = IFU_ST_REQ;
        IFU_ST_ERR:   if (imem_rsp_valid) drop_n = 1'b0;
        default:      state_n = IFU_ST_START;
      endcase
    end
  end

  assign rsp_pkt = '{pc: pc, instr: imem_rsp_data};

  ifu_buf u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (buf_load),
    .load_pkt (rsp_pkt),
    .squash   (redirect_valid),
    .out_ready(if_ready),
    .valid    (buf_valid),
    .pkt      (buf_pkt)
  );

  // A same-cycle redirect hides the buffered instruction so decode never takes a wrong-path transfer.
  assign if_valid      = buf_valid && !redirect_valid;
  assign if_pc         = buf_pkt.pc;
  assign if_instr      = buf_pkt.instr;
  assign imem_req_addr = pc;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus random traffic against a stream-level reference model.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_misaligned;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .fetch_misaligned(fetch_misaligned)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
  endfunction

  // Reference: next PC decode must see, error mode, and a one-slot memory model.
  logic [31:0] exp_pc, rsp_addr, prev_addr, force_pc, last_addr, last_xfer_pc;
  bit          m_err, pend, prev_stall, force_redir, at_neg;
  bit          last_acc, last_xfer, s_ifv, s_reqv, s_mis;
  int          rsp_cnt, idle, cyc, last_acc_cyc;
  int unsigned ready_pct, ifr_pct, redir_pct, lat_min, lat_max;
  int          acc_cyc[$];
  logic [31:0] acc_addr[$];
  int          xf_cyc[$];

  task automatic do_reset();
    #2 rst_n = 1'b0;
    redirect_valid = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; if_ready = 1'b0;
    redirect_pc = '0; imem_rsp_data = '0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_misaligned", 32'(fetch_misaligned), 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_req_addr", imem_req_addr, RST_PC);
    exp_pc = RST_PC; m_err = 0; pend = 0; prev_stall = 0; rsp_cnt = 0; idle = 0;
    force_redir = 0;
    acc_cyc.delete(); acc_addr.delete(); xf_cyc.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; cyc = 0; at_neg = 0;
  endtask

  // One cycle: drive after the edge, sample and check at the falling edge, advance the model.
  task automatic step();
    logic [31:0] r;
    if (at_neg) begin @(posedge clk); #1; end
    imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin imem_rsp_valid = 1'b1; imem_rsp_data = memf(rsp_addr); end
    end
    imem_req_ready = ($urandom_range(99) < ready_pct);
    if_ready       = ($urandom_range(99) < ifr_pct);
    redirect_valid = 1'b0; redirect_pc = $urandom;
    if (force_redir) begin
      redirect_valid = 1'b1; redirect_pc = force_pc; force_redir = 0;
    end else if ($urandom_range(99) < redir_pct) begin
      r = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(99) < 20) r[1:0] = 2'($urandom_range(3, 1));
      redirect_valid = 1'b1; redirect_pc = r;
    end
    @(negedge clk);
    at_neg = 1;
    s_ifv = if_valid; s_reqv = imem_req_valid; s_mis = fetch_misaligned;
    check("misaligned", 32'(fetch_misaligned), 32'(m_err));
    if (redirect_valid) check("redir_mask", 32'(if_valid), 32'd0);
    if (m_err) begin
      check("err_req", 32'(imem_req_valid), 32'd0);
      check("err_ifv", 32'(if_valid), 32'd0);
    end
    if (prev_stall) begin
      check("stall_valid", 32'(imem_req_valid), 32'd1);
      check("stall_addr", imem_req_addr, prev_addr);
    end
    prev_stall = imem_req_valid && !imem_req_ready && !redirect_valid;
    prev_addr  = imem_req_addr;
    if (imem_rsp_valid) pend = 0;
    last_acc = imem_req_valid && imem_req_ready;
    if (last_acc) begin
      check("one_outstanding", 32'(pend), 32'd0);
      check("req_addr", imem_req_addr, exp_pc);
      pend = 1; rsp_addr = imem_req_addr; rsp_cnt = int'($urandom_range(lat_max, lat_min));
      last_addr = imem_req_addr; last_acc_cyc = cyc;
      acc_cyc.push_back(cyc); acc_addr.push_back(imem_req_addr);
    end
    if (if_valid) check("instr_data", if_instr, memf(if_pc));
    last_xfer = if_valid && if_ready;
    if (last_xfer) begin
      check("xfer_pc", if_pc, exp_pc);
      last_xfer_pc = if_pc; xf_cyc.push_back(cyc);
      exp_pc = exp_pc + 32'd4;
    end
    if (redirect_valid) begin
      exp_pc = redirect_pc;
      m_err  = (redirect_pc[1:0] != 2'b00);
    end
    if (last_acc || last_xfer || m_err) idle = 0; else idle++;
    if (idle > 300) begin check("stall_watchdog", 32'(idle), 32'd0); idle = 0; end
    cyc++;
  endtask

  task automatic wait_acc(input int budget);
    int i = 0;
    do begin step(); i++; end while (!last_acc && i < budget);
    check("acc_timeout", 32'(last_acc), 32'd1);
  endtask

  task automatic wait_xfer(input int budget);
    int i = 0;
    do begin step(); i++; end while (!last_xfer && i < budget);
    check("xfer_timeout", 32'(last_xfer), 32'd1);
  endtask

  initial begin
    logic [31:0] hp, hi;
    int c, n;
    ready_pct = 100; ifr_pct = 100; redir_pct = 0; lat_min = 1; lat_max = 1;
    at_neg = 0;
    do_reset();

    // Streaming from reset: accept at 1,4,7 and deliver at 3,6,9.
    for (int i = 0; i < 10; i++) step();
    check("t1_acc0_cyc", 32'(acc_cyc[0]), 32'd1);
    check("t1_acc0", acc_addr[0], 32'hBFC0_0000);
    check("t1_acc1", acc_addr[1], 32'hBFC0_0004);
    check("t1_acc2", acc_addr[2], 32'hBFC0_0008);
    check("t1_acc2_cyc", 32'(acc_cyc[2]), 32'd7);
    check("t1_xf0_cyc", 32'(xf_cyc[0]), 32'd3);
    check("t1_xf2_cyc", 32'(xf_cyc[2]), 32'd9);

    // Decode stalls for several cycles in HOLD.
    ifr_pct = 0;
    n = 0;
    do begin step(); n++; end while (!s_ifv && n < 10);
    check("t2_reach", 32'(s_ifv), 32'd1);
    hp = if_pc; hi = if_instr;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_ifv", 32'(s_ifv), 32'd1);
      check("t2_pc", if_pc, hp);
      check("t2_instr", if_instr, hi);
      check("t2_noreq", 32'(s_reqv), 32'd0);
    end
    ifr_pct = 100;
    step();
    check("t2_xfer", 32'(last_xfer), 32'd1);
    step();
    check("t2_req", 32'(last_acc), 32'd1);
    check("t2_addr", last_addr, hp + 32'd4);

    // Redirect in WAIT; the slow response must be dropped.
    lat_min = 3; lat_max = 3;
    wait_acc(20);
    c = last_acc_cyc;
    force_redir = 1; force_pc = 32'h0040_0000;
    n = 0;
    step(); n += int'(s_ifv);
    for (int i = 0; i < 20 && !last_acc; i++) begin step(); n += int'(s_ifv); end
    check("t3_no_ifv", 32'(n), 32'd0);
    check("t3_addr", last_addr, 32'h0040_0000);
    check("t3_acc_cyc", 32'(last_acc_cyc), 32'(c + 4));
    lat_min = 1; lat_max = 1;
    wait_xfer(20);
    check("t3_xfer_pc", last_xfer_pc, 32'h0040_0000);

    // Redirect coincident with if_ready in HOLD.
    ifr_pct = 0;
    n = 0;
    do begin step(); n++; end while (!s_ifv && n < 20);
    check("t4_reach", 32'(s_ifv), 32'd1);
    ifr_pct = 100; force_redir = 1; force_pc = 32'h0040_0100;
    step();
    check("t4_mask", 32'(s_ifv), 32'd0);
    check("t4_noxfer", 32'(last_xfer), 32'd0);
    wait_acc(20);
    check("t4_addr", last_addr, 32'h0040_0100);

    // Misaligned target, then recovery by an aligned redirect.
    force_redir = 1; force_pc = 32'h0040_0002;
    step();
    step();
    check("t5_set", 32'(s_mis), 32'd1);
    n = 0;
    for (int i = 0; i < 5; i++) begin step(); n += int'(s_reqv); end
    check("t5_noreq", 32'(n), 32'd0);
    force_redir = 1; force_pc = 32'h0040_0010;
    step();
    step();
    check("t5_clear", 32'(s_mis), 32'd0);
    if (!last_acc) wait_acc(20);
    check("t5_addr", last_addr, 32'h0040_0010);

    // PC wraps past the top of the address space.
    force_redir = 1; force_pc = 32'hFFFF_FFFC;
    wait_xfer(30);
    check("t6_xfer_pc", last_xfer_pc, 32'hFFFF_FFFC);
    wait_acc(20);
    check("t6_wrap", last_addr, 32'h0000_0000);

    // Random traffic with back-pressure, variable latency and redirects.
    ready_pct = 70; ifr_pct = 70; redir_pct = 4; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) step();

    // Reset in the middle of traffic.
    ready_pct = 100; ifr_pct = 100; redir_pct = 0; lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    check("t7_acc0_cyc", 32'(acc_cyc[0]), 32'd1);
    check("t7_acc0", acc_addr[0], RST_PC);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
